// File: rtl/input_port_buffer.sv
// Credit-returning input FIFO with packet header tracking; flits appear on ib_data_o one cycle after write.
// No internal stall: writes into a full FIFO are dropped and flagged, reads on empty are ignored and flagged.
module input_port_buffer #(
   parameter int FLIT_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int PKT_LEN    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [FLIT_WIDTH-1:0] ib_data_i,
   input  logic                  ib_valid_i,
   output logic                  ib_credit_o,
   input  logic                  ib_read_i,
   output logic [FLIT_WIDTH-1:0] ib_data_o,
   output logic                  ib_empty_o,
   output logic                  ib_header_valid_o,
   output logic [15:0]           ib_addr_header_o,
   output logic                  ib_overflow_o,
   output logic                  ib_underflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(PKT_LEN);

   typedef enum logic {HEAD = 1'b0, BODY = 1'b1} pkt_state_t;

   logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
   logic [FLIT_WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   pkt_state_t            state_q, state_d;
   logic [PW-1:0]         pkt_cnt_q, pkt_cnt_d;
   logic [15:0]           hdr_q, hdr_d;
   logic                  credit_q, credit_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic                  rd_acc, wr_acc;

   assign ib_data_o         = mem_q[rd_ptr_q];
   assign ib_empty_o        = (count_q == '0);
   assign ib_header_valid_o = (state_q == HEAD) && !ib_empty_o;
   assign ib_addr_header_o  = ib_header_valid_o ? ib_data_o[15:0] : hdr_q;
   assign ib_credit_o       = credit_q;
   assign ib_overflow_o     = ovf_q;
   assign ib_underflow_o    = udf_q;

   // A read frees a slot in the same cycle, so a full FIFO still accepts a concurrent write.
   always_comb begin
      rd_acc = ib_read_i && (count_q != '0);
      wr_acc = ib_valid_i && ((count_q < CW'(DEPTH)) || rd_acc);
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         mem_d[wr_ptr_q] = ib_data_i;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      credit_d = rd_acc;
      ovf_d    = ovf_q || (ib_valid_i && !wr_acc);
      udf_d    = udf_q || (ib_read_i && !rd_acc);
   end

   always_comb begin
      state_d   = state_q;
      pkt_cnt_d = pkt_cnt_q;
      hdr_d     = hdr_q;
      case (state_q)
         HEAD: begin
            if (rd_acc) begin
               state_d   = BODY;
               pkt_cnt_d = PW'(1);
               hdr_d     = ib_data_o[15:0];
            end
         end
         BODY: begin
            if (rd_acc) begin
               if (pkt_cnt_q == PW'(PKT_LEN - 1)) begin
                  state_d   = HEAD;
                  pkt_cnt_d = '0;
               end else begin
                  pkt_cnt_d = pkt_cnt_q + PW'(1);
               end
            end
         end
         default: begin
            state_d   = HEAD;
            pkt_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= HEAD;
         pkt_cnt_q <= '0;
         hdr_q     <= '0;
         credit_q  <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         pkt_cnt_q <= pkt_cnt_d;
         hdr_q     <= hdr_d;
         credit_q  <= credit_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
      end
   end

   // Storage needs no reset: contents are only observable once count marks them valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed checks of the input port buffer: FIFO order, packet header tracking, credits, error flags, reset.
module tb_input_port_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ib_data_i;
   logic        ib_valid_i;
   logic        ib_credit_o;
   logic        ib_read_i;
   logic [31:0] ib_data_o;
   logic        ib_empty_o;
   logic        ib_header_valid_o;
   logic [15:0] ib_addr_header_o;
   logic        ib_overflow_o;
   logic        ib_underflow_o;

   int n_cmp = 0;
   int n_mis = 0;
   int credit_sum;

   input_port_buffer #(.FLIT_WIDTH(32), .DEPTH(4), .PKT_LEN(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .ib_data_i         (ib_data_i),
      .ib_valid_i        (ib_valid_i),
      .ib_credit_o       (ib_credit_o),
      .ib_read_i         (ib_read_i),
      .ib_data_o         (ib_data_o),
      .ib_empty_o        (ib_empty_o),
      .ib_header_valid_o (ib_header_valid_o),
      .ib_addr_header_o  (ib_addr_header_o),
      .ib_overflow_o     (ib_overflow_o),
      .ib_underflow_o    (ib_underflow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      ib_valid_i = 1'b0;
      ib_read_i  = 1'b0;
      ib_data_i  = '0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic push(input logic [31:0] d);
      ib_valid_i = 1'b1;
      ib_data_i  = d;
      step();
      ib_valid_i = 1'b0;
   endtask

   initial begin
      ib_valid_i = 1'b0;
      ib_read_i  = 1'b0;
      ib_data_i  = '0;
      reset      = 1'b0;
      step();
      step();
      chk("rst_empty",  {31'd0, ib_empty_o}, 32'd1);
      chk("rst_hv",     {31'd0, ib_header_valid_o}, 32'd0);
      chk("rst_addr",   {16'd0, ib_addr_header_o}, 32'h0);
      chk("rst_credit", {31'd0, ib_credit_o}, 32'd0);
      chk("rst_ovf",    {31'd0, ib_overflow_o}, 32'd0);
      chk("rst_udf",    {31'd0, ib_underflow_o}, 32'd0);
      reset = 1'b1;

      // single flit: no bypass, header visible, credit one cycle after the pop
      push(32'hA5A5_0023);
      chk("one_empty", {31'd0, ib_empty_o}, 32'd0);
      chk("one_hv",    {31'd0, ib_header_valid_o}, 32'd1);
      chk("one_addr",  {16'd0, ib_addr_header_o}, 32'h0023);
      chk("one_data",  ib_data_o, 32'hA5A5_0023);
      ib_read_i = 1'b1;
      step();
      ib_read_i = 1'b0;
      chk("one_credit", {31'd0, ib_credit_o}, 32'd1);
      chk("one_empty2", {31'd0, ib_empty_o}, 32'd1);
      chk("one_addr2",  {16'd0, ib_addr_header_o}, 32'h0023);
      step();
      chk("one_credit_end", {31'd0, ib_credit_o}, 32'd0);

      // full packet: address held through the body, FSM back to HEAD afterwards
      do_reset();
      push(32'h0000_0012);
      push(32'h1111_FFFF);
      push(32'h2222_FFFF);
      push(32'h3333_FFFF);
      chk("pkt_hv_h",   {31'd0, ib_header_valid_o}, 32'd1);
      chk("pkt_addr_h", {16'd0, ib_addr_header_o}, 32'h0012);
      credit_sum = 0;
      ib_read_i  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         credit_sum += int'(ib_credit_o);
         chk($sformatf("pkt_addr_%0d", i), {16'd0, ib_addr_header_o}, 32'h0012);
         chk($sformatf("pkt_hv_%0d", i), {31'd0, ib_header_valid_o}, 32'd0);
      end
      ib_read_i = 1'b0;
      chk("pkt_empty", {31'd0, ib_empty_o}, 32'd1);
      step();
      credit_sum += int'(ib_credit_o);
      step();
      credit_sum += int'(ib_credit_o);
      chk("pkt_credits", credit_sum, 32'd4);
      push(32'h0000_0077);
      chk("pkt_next_hv",   {31'd0, ib_header_valid_o}, 32'd1);
      chk("pkt_next_addr", {16'd0, ib_addr_header_o}, 32'h0077);

      // overflow: extra flit dropped, then a read+write on a full FIFO is accepted
      do_reset();
      for (int i = 0; i < 4; i++) push(32'h100 + i);
      chk("ovf_pre", {31'd0, ib_overflow_o}, 32'd0);
      push(32'h0000_0BAD);
      chk("ovf_set",  {31'd0, ib_overflow_o}, 32'd1);
      chk("ovf_head", ib_data_o, 32'h100);
      ib_valid_i = 1'b1;
      ib_data_i  = 32'h104;
      ib_read_i  = 1'b1;
      step();
      ib_valid_i = 1'b0;
      chk("ovf_rw_credit", {31'd0, ib_credit_o}, 32'd1);
      chk("ovf_rw_udf",    {31'd0, ib_underflow_o}, 32'd0);
      chk("ovf_rw_head",   ib_data_o, 32'h101);
      step();
      chk("ovf_d2", ib_data_o, 32'h102);
      step();
      chk("ovf_d3", ib_data_o, 32'h103);
      step();
      chk("ovf_d4", ib_data_o, 32'h104);
      chk("ovf_ne", {31'd0, ib_empty_o}, 32'd0);
      step();
      ib_read_i = 1'b0;
      chk("ovf_drained", {31'd0, ib_empty_o}, 32'd1);
      chk("ovf_sticky",  {31'd0, ib_overflow_o}, 32'd1);

      // underflow with a simultaneous write
      do_reset();
      ib_read_i  = 1'b1;
      ib_valid_i = 1'b1;
      ib_data_i  = 32'hCAFE_0042;
      step();
      ib_read_i  = 1'b0;
      ib_valid_i = 1'b0;
      chk("udf_credit", {31'd0, ib_credit_o}, 32'd0);
      chk("udf_set",    {31'd0, ib_underflow_o}, 32'd1);
      chk("udf_empty",  {31'd0, ib_empty_o}, 32'd0);
      chk("udf_data",   ib_data_o, 32'hCAFE_0042);
      chk("udf_hv",     {31'd0, ib_header_valid_o}, 32'd1);
      chk("udf_addr",   {16'd0, ib_addr_header_o}, 32'h0042);
      chk("udf_ovf",    {31'd0, ib_overflow_o}, 32'd0);

      // streaming 10 flits with concurrent read/write, pointers wrap twice
      do_reset();
      push(32'h5000_0000);
      credit_sum = 0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("strm_data_%0d", i), ib_data_o, 32'h5000_0000 + i);
         chk($sformatf("strm_hv_%0d", i), {31'd0, ib_header_valid_o}, {31'd0, (i % 4) == 0});
         ib_read_i  = 1'b1;
         ib_valid_i = (i < 9);
         ib_data_i  = 32'h5000_0000 + i + 1;
         step();
         credit_sum += int'(ib_credit_o);
      end
      ib_read_i  = 1'b0;
      ib_valid_i = 1'b0;
      chk("strm_credits", credit_sum, 32'd10);
      chk("strm_empty",   {31'd0, ib_empty_o}, 32'd1);
      step();
      chk("strm_credit_end", {31'd0, ib_credit_o}, 32'd0);

      // reset mid-packet with traffic in flight
      do_reset();
      push(32'hAAAA_0055);
      for (int i = 1; i < 4; i++) push(32'hBBBB_0000 + i);
      push(32'h0000_0BAD);
      ib_read_i = 1'b1;
      step();
      step();
      chk("mid_credit", {31'd0, ib_credit_o}, 32'd1);
      chk("mid_ovf",    {31'd0, ib_overflow_o}, 32'd1);
      chk("mid_addr",   {16'd0, ib_addr_header_o}, 32'h0055);
      chk("mid_hv",     {31'd0, ib_header_valid_o}, 32'd0);
      reset      = 1'b0;
      ib_valid_i = 1'b1;
      ib_data_i  = 32'hDEAD_BEEF;
      step();
      chk("mrst_empty",  {31'd0, ib_empty_o}, 32'd1);
      chk("mrst_credit", {31'd0, ib_credit_o}, 32'd0);
      chk("mrst_ovf",    {31'd0, ib_overflow_o}, 32'd0);
      chk("mrst_udf",    {31'd0, ib_underflow_o}, 32'd0);
      chk("mrst_hv",     {31'd0, ib_header_valid_o}, 32'd0);
      chk("mrst_addr",   {16'd0, ib_addr_header_o}, 32'h0);
      reset      = 1'b1;
      ib_read_i  = 1'b0;
      ib_valid_i = 1'b0;
      push(32'h0000_0099);
      chk("mrst_hv_head", {31'd0, ib_header_valid_o}, 32'd1);
      chk("mrst_addr2",   {16'd0, ib_addr_header_o}, 32'h0099);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
